lfclk_gen: RTL and testbench
============================

Name: lfclk_gen

Overview:
- Generates the always-on low-frequency clock (~32.768 kHz) for the SoC AON/RTC domain from clk_8388; output feeds e203_soc_top lfextclk.
- Replaces the free-running divider with a lock-qualified, settle-timed divider.
- Also provides a single-cycle tick strobe, a valid flag and a running tick count in the clk_8388 domain.
- Sits between the MMCM (clk_8388, mmcm_locked) and the SoC lfextclk input.

Parameters:
DIV, 256, divide ratio clk_8388 -> lfclk; even, >= 4
SETTLE_CYC, 1024, clk_8388 cycles lock must stay high before lfclk starts; >= 1
SYNC_STAGES, 2, synchroniser depth for mmcm_locked; >= 2

Ports:
clk_8388  in  1  divider clock (MMCM clk_out1)
ck_rst  in  1  asynchronous active-low reset
mmcm_locked  in  1  MMCM lock, asynchronous to clk_8388
lfclk  out  1  divided clock, 50% duty, registered (drives lfextclk)
lf_tick  out  1  one clk_8388-cycle pulse coincident with each lfclk rising edge
lf_valid  out  1  high while lfclk is running
lf_cnt  out  32  count of lfclk rising edges since last entry to RUN

Behaviour:
- Reset and clock: reset is ck_rst, asynchronous, active-low; clock is clk_8388.
- Reset values (ck_rst low):
  - state = WAIT_LOCK; synchroniser flops 0; settle_cnt 0; div_cnt 0.
  - lfclk 0, lf_tick 0, lf_valid 0, lf_cnt 0.
  - All outputs are direct flop outputs; no combinational paths to outputs.
- Lock synchroniser:
  - mmcm_locked passes through a SYNC_STAGES flop chain to give lock_s.
  - Latency is SYNC_STAGES edges.
- State machine (states WAIT_LOCK, SETTLE, RUN):
  - WAIT_LOCK:
    - settle_cnt held at 0; lfclk, lf_tick and lf_valid are 0.
    - If lock_s = 1, go to SETTLE.
  - SETTLE:
    - settle_cnt increments by 1 each cycle.
    - If lock_s = 0, go to WAIT_LOCK and clear settle_cnt. The timer restarts; it does not resume.
    - If settle_cnt == SETTLE_CYC-1 and lock_s = 1, go to RUN.
    - On that same edge: div_cnt <= 0, lfclk <= 1, lf_tick <= 1, lf_valid <= 1, lf_cnt <= 1.
  - RUN:
    - div_cnt counts 0..DIV-1, then wraps to 0.
    - On each edge:
      - lfclk <= (div_cnt_next < DIV/2).
      - lf_tick <= (div_cnt_next == 0).
      - When div_cnt_next == 0, lf_cnt <= lf_cnt + 1, modulo 2^32 (0xFFFFFFFF wraps to 0).
    - Result: lfclk is high for DIV/2 cycles, then low for DIV/2 cycles, with period DIV.
    - lf_tick is high for exactly 1 cycle per period, aligned with the cycle in which lfclk first reads 1.
    - If lock_s = 0, go to WAIT_LOCK. On that edge: lfclk <= 0, lf_tick <= 0, lf_valid <= 0, div_cnt <= 0.
    - lf_cnt holds its value on lock loss; it is reloaded to 1 on the next entry to RUN.
    - A high phase truncated by lock loss is accepted; lfclk never glitches within a cycle because it is a flop.
- Timing from lock to first lfclk edge:
  - mmcm_locked rises before edge 0.
  - lock_s = 1 after SYNC_STAGES edges.
  - SETTLE is entered 1 edge later and occupies SETTLE_CYC cycles.
  - RUN and the first lfclk rise follow on the next edge.
  - Bench tolerance: ±1 cycle.
- Asynchronous reset mid-operation: all state returns to reset values immediately. lfclk may drop mid-phase.
- Widths:
  - settle_cnt and div_cnt use $clog2(SETTLE_CYC) and $clog2(DIV) bits (minimum 1 bit).
  - Comparisons are unsigned.

Test Plan:
1. Defaults; ck_rst released with mmcm_locked = 0 for 5000 cycles -> lfclk = 0, lf_tick = 0, lf_valid = 0, lf_cnt = 0 throughout.
2. Defaults; mmcm_locked rises and stays high -> first lfclk rise 1027 ± 1 cycles later.
   - Thereafter period 256, high 128, low 128.
   - lf_tick width 1, once per period.
   - lf_cnt = 1, 2, 3 ... incrementing on each tick.
3. SETTLE_CYC = 16: lock high for 10 cycles, low for 3 cycles, high again -> settle timer restarts.
   - First lfclk rise is 16 + SYNC_STAGES + 1 cycles after the second rise, not earlier.
4. DIV = 4, SETTLE_CYC = 1, running:
   - Deassert lock -> SYNC_STAGES + 1 cycles later lfclk = 0, lf_valid = 0, lf_cnt frozen.
   - Reassert lock -> lf_cnt restarts at 1.
5. Running with DIV = 4: force lf_cnt to 0xFFFFFFFE -> subsequent ticks show 0xFFFFFFFF, then 0x00000000.
6. Pull ck_rst low mid high phase -> lfclk, lf_valid, lf_tick and lf_cnt go to 0 asynchronously, with no clock edge needed.
   - After release with lock held high, the full settle sequence repeats.

Source files
------------

// File: rtl/lfclk_gen.sv
// ---------------------------------------------------------------------------
// lfclk_gen
//   Lock-qualified, settle-timed divider producing the always-on ~32.768 kHz
//   clock for the AON/RTC domain (drives lfextclk) from the MMCM clk_8388.
//   lfclk only starts once mmcm_locked has been continuously high for
//   SETTLE_CYC cycles, and stops as soon as lock is lost.
//
//   State table
//     state     | meaning
//     WAIT_LOCK | lock not seen; divider idle, outputs low
//     SETTLE    | lock seen; timing SETTLE_CYC cycles of continuous lock
//     RUN       | lfclk running, lf_tick/lf_cnt active
//
// Ports
//   clk_8388    in   divider clock (MMCM clk_out1)
//   ck_rst      in   asynchronous active-low reset
//   mmcm_locked in   MMCM lock, asynchronous to clk_8388
//   lfclk       out  divided clock, 50% duty, registered
//   lf_tick     out  one-cycle pulse on each lfclk rising edge
//   lf_valid    out  high while lfclk is running
//   lf_cnt      out  lfclk rising edges since last entry to RUN
// ---------------------------------------------------------------------------
module lfclk_gen #(
    parameter int DIV         = 256,
    parameter int SETTLE_CYC  = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_8388,
    input  logic        ck_rst,
    input  logic        mmcm_locked,
    output logic        lfclk,
    output logic        lf_tick,
    output logic        lf_valid,
    output logic [31:0] lf_cnt
);

    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [DW-1:0] DIV_LAST    = DW'(DIV - 1);
    localparam logic [DW-1:0] DIV_HALF    = DW'(DIV / 2);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    logic [SW-1:0]          settle_cnt, settle_d;
    logic [DW-1:0]          div_cnt, div_d, div_nxt;
    logic                   lfclk_d, tick_d, valid_d;
    logic [31:0]            cnt_d;

    // Lock synchroniser: mmcm_locked shifts in at bit 0, lock_s at the top.
    always_ff @(posedge clk_8388 or negedge ck_rst) begin
        if (!ck_rst) sync_q <= '0;
        else         sync_q <= {sync_q[SYNC_STAGES-2:0], mmcm_locked};
    end

    assign lock_s  = sync_q[SYNC_STAGES-1];
    assign div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);

    // State register
    always_ff @(posedge clk_8388 or negedge ck_rst) begin
        if (!ck_rst) state_q <= WAIT_LOCK;
        else         state_q <= state_d;
    end

    // Next-state logic; lock loss always wins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_LOCK: if (lock_s) state_d = SETTLE;
            SETTLE: begin
                if (!lock_s)                        state_d = WAIT_LOCK;
                else if (settle_cnt == SETTLE_LAST) state_d = RUN;
            end
            RUN:       if (!lock_s) state_d = WAIT_LOCK;
            default:   state_d = WAIT_LOCK;
        endcase
    end

    // Output / datapath next values. Everything defaults to the idle values,
    // so any exit to WAIT_LOCK clears the timer, divider and clock outputs
    // while lf_cnt holds.
    always_comb begin
        settle_d = '0;
        div_d    = '0;
        lfclk_d  = 1'b0;
        tick_d   = 1'b0;
        valid_d  = 1'b0;
        cnt_d    = lf_cnt;
        case (state_q)
            SETTLE: begin
                if (lock_s) begin
                    if (settle_cnt == SETTLE_LAST) begin
                        // First lfclk rising edge comes with RUN entry.
                        lfclk_d = 1'b1;
                        tick_d  = 1'b1;
                        valid_d = 1'b1;
                        cnt_d   = 32'd1;
                    end else begin
                        settle_d = settle_cnt + SW'(1);
                    end
                end
            end
            RUN: begin
                if (lock_s) begin
                    div_d   = div_nxt;
                    lfclk_d = (div_nxt < DIV_HALF);
                    tick_d  = (div_nxt == '0);
                    valid_d = 1'b1;
                    if (div_nxt == '0) cnt_d = lf_cnt + 32'd1;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk_8388 or negedge ck_rst) begin
        if (!ck_rst) begin
            settle_cnt <= '0;
            div_cnt    <= '0;
            lfclk      <= 1'b0;
            lf_tick    <= 1'b0;
            lf_valid   <= 1'b0;
            lf_cnt     <= '0;
        end else begin
            settle_cnt <= settle_d;
            div_cnt    <= div_d;
            lfclk      <= lfclk_d;
            lf_tick    <= tick_d;
            lf_valid   <= valid_d;
            lf_cnt     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_lfclk_gen.sv
// ---------------------------------------------------------------------------
// tb_lfclk_gen
//   Three lfclk_gen instances share clk_8388, each with its own reset/lock:
//     0: defaults              (idle, lock-to-clock timing, duty, async reset)
//     1: DIV=4, SETTLE_CYC=16  (settle timer restart on lock glitch)
//     2: DIV=4, SETTLE_CYC=1   (lock loss/regain, lf_cnt wrap)
//   Expected ticks (count value and cycle) are queued when lock/reset/force
//   stimulus is applied and popped as lf_tick pulses arrive.
// ---------------------------------------------------------------------------
module tb_lfclk_gen;

    logic clk_8388 = 1'b0;
    always #5 clk_8388 = ~clk_8388;

    logic [2:0]  rst_v  = 3'b000;
    logic [2:0]  lock_v = 3'b000;
    logic [2:0]  lfclk_v, tick_v, valid_v;
    logic [31:0] cnt0, cnt1, cnt2;

    int cyc = 0;
    always @(posedge clk_8388) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] cnt;
        int          cyc;
    } exp_t;
    exp_t sbq[$];

    lfclk_gen u_def (
        .clk_8388(clk_8388), .ck_rst(rst_v[0]), .mmcm_locked(lock_v[0]),
        .lfclk(lfclk_v[0]), .lf_tick(tick_v[0]), .lf_valid(valid_v[0]), .lf_cnt(cnt0)
    );

    lfclk_gen #(.DIV(4), .SETTLE_CYC(16), .SYNC_STAGES(2)) u_settle (
        .clk_8388(clk_8388), .ck_rst(rst_v[1]), .mmcm_locked(lock_v[1]),
        .lfclk(lfclk_v[1]), .lf_tick(tick_v[1]), .lf_valid(valid_v[1]), .lf_cnt(cnt1)
    );

    lfclk_gen #(.DIV(4), .SETTLE_CYC(1), .SYNC_STAGES(2)) u_fast (
        .clk_8388(clk_8388), .ck_rst(rst_v[2]), .mmcm_locked(lock_v[2]),
        .lfclk(lfclk_v[2]), .lf_tick(tick_v[2]), .lf_valid(valid_v[2]), .lf_cnt(cnt2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     tag, obs, obs, exp, exp, cyc);
        end
    endtask

    function automatic logic [31:0] get_cnt(input int idx);
        case (idx)
            0:       return cnt0;
            1:       return cnt1;
            default: return cnt2;
        endcase
    endfunction

    task automatic push(input logic [31:0] c, input int at);
        exp_t e;
        e.cnt = c;
        e.cyc = at;
        sbq.push_back(e);
    endtask

    // Sample at negedges until every queued tick has been seen or the budget
    // runs out. Tick timing is accepted within +/-1 cycle.
    task automatic mon(input int idx, input int budget, input string tag);
        int   n    = 0;
        int   dbl  = 0;
        int   diff;
        logic prev = 1'b0;
        exp_t e;
        while (sbq.size() > 0 && n < budget) begin
            @(negedge clk_8388);
            n++;
            if (tick_v[idx]) begin
                e    = sbq.pop_front();
                diff = cyc - e.cyc;
                chk({tag, "_cnt"}, get_cnt(idx), e.cnt);
                chk({tag, "_time_err"}, (diff >= -1 && diff <= 1) ? 0 : diff, 0);
                if (prev) dbl++;
            end
            prev = tick_v[idx];
        end
        if (sbq.size() != 0) begin
            chk({tag, "_timeout_left"}, sbq.size(), 0);
            sbq.delete();
        end
        chk({tag, "_tick_width_err"}, dbl, 0);
    endtask

    initial begin
        int bad;
        int t0;
        int hi;
        int lo;

        // Reset state
        repeat (3) @(negedge clk_8388);
        chk("rst_lfclk", lfclk_v[0], 0);
        chk("rst_tick",  tick_v[0],  0);
        chk("rst_valid", valid_v[0], 0);
        chk("rst_cnt",   cnt0,       0);

        // 1: no lock for 5000 cycles
        rst_v = 3'b001;
        bad   = 0;
        repeat (5000) begin
            @(negedge clk_8388);
            if (lfclk_v[0] || tick_v[0] || valid_v[0] || (cnt0 != 0)) bad++;
        end
        chk("t1_idle_bad_cycles", bad, 0);

        // 2: lock rises -> first rise 1027 cycles later, then period 256
        lock_v[0] = 1'b1;
        t0 = cyc;
        for (int k = 0; k < 4; k++) push(32'(k + 1), t0 + 1027 + 256 * k);
        mon(0, 2500, "t2");
        chk("t2_valid", valid_v[0], 1);
        hi = 0;
        while (lfclk_v[0] && hi < 1000) begin hi++; @(negedge clk_8388); end
        lo = 0;
        while (!lfclk_v[0] && lo < 1000) begin lo++; @(negedge clk_8388); end
        chk("t2_high_cycles", hi, 128);
        chk("t2_low_cycles",  lo, 128);

        // 6: async reset mid high phase, then full settle again
        repeat (5) @(negedge clk_8388);
        chk("t6_pre_lfclk", lfclk_v[0], 1);
        #2 rst_v[0] = 1'b0;
        #1;
        chk("t6_async_lfclk", lfclk_v[0], 0);
        chk("t6_async_valid", valid_v[0], 0);
        chk("t6_async_tick",  tick_v[0],  0);
        chk("t6_async_cnt",   cnt0,       0);
        @(negedge clk_8388);
        rst_v[0] = 1'b1;
        t0 = cyc;
        push(32'd1, t0 + 1027);
        mon(0, 1500, "t6");

        // 3: lock glitch restarts the settle timer
        rst_v[1] = 1'b1;
        repeat (5) @(negedge clk_8388);
        lock_v[1] = 1'b1;
        repeat (10) @(negedge clk_8388);
        lock_v[1] = 1'b0;
        repeat (3) @(negedge clk_8388);
        chk("t3_valid_during_glitch", valid_v[1], 0);
        lock_v[1] = 1'b1;
        t0 = cyc;
        push(32'd1, t0 + 19);
        push(32'd2, t0 + 23);
        mon(1, 100, "t3");

        // 4: lock loss and regain, DIV=4, SETTLE_CYC=1
        lock_v[2] = 1'b1;
        @(negedge clk_8388);
        rst_v[2] = 1'b1;
        t0 = cyc;
        for (int k = 0; k < 3; k++) push(32'(k + 1), t0 + 4 + 4 * k);
        mon(2, 100, "t4a");
        lock_v[2] = 1'b0;
        repeat (2) @(negedge clk_8388);
        chk("t4_valid_before_loss", valid_v[2], 1);
        @(negedge clk_8388);
        chk("t4_lfclk_after_loss", lfclk_v[2], 0);
        chk("t4_valid_after_loss", valid_v[2], 0);
        chk("t4_cnt_after_loss",   cnt2,       3);
        repeat (20) @(negedge clk_8388);
        chk("t4_cnt_frozen", cnt2, 3);
        lock_v[2] = 1'b1;
        t0 = cyc;
        push(32'd1, t0 + 4);
        push(32'd2, t0 + 8);
        mon(2, 100, "t4b");

        // 5: lf_cnt wraps through 0xFFFFFFFF to 0
        force u_fast.lf_cnt = 32'hFFFF_FFFE;
        t0 = cyc;
        push(32'hFFFF_FFFF, t0 + 4);
        push(32'h0000_0000, t0 + 8);
        @(posedge clk_8388);
        @(negedge clk_8388);
        release u_fast.lf_cnt;
        mon(2, 100, "t5");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
